// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
// Shared definitions for the UART image-frame loader: FSM state encoding,
// default sync-header bytes and the default inter-byte timeout.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC0_DEF   = 8'h55;
  localparam logic [7:0] SYNC1_DEF   = 8'hAA;
  localparam int         TIMEOUT_DEF = 50_000;

  // Width needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_gap_timer.sv
// byte_gap_timer
// Counts idle clocks between received bytes while the frame FSM is waiting
// for header or pixel data.
//   sys_clk     in   clock
//   sys_rst_n   in   asynchronous active-low reset
//   clear_i     in   restart the count (a byte arrived)
//   run_i       in   count enable; the count is held at zero while low
//   expired_o   out  high on the cycle the count sits at TIMEOUT_CYC-1 with
//                    no byte arriving (combinational; the FSM registers it)
module byte_gap_timer
  import uart_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int                CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Dropping run_i on every exit from SYNC/LOAD zeroes the count, so any
  // later entry into a running state starts from zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || !run_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A byte on the limit cycle suppresses expiry: the byte wins.
  assign expired_o = run_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Receives an image frame from a UART byte stream: a two-byte sync header
// (SYNC0, SYNC1) followed by IMG_W*IMG_H pixel bytes written in raster order
// to a frame buffer. Driven directly by the UART receiver's po_data/po_flag.
//   sys_clk      in   clock
//   sys_rst_n    in   asynchronous active-low reset
//   pi_data      in   received byte, valid with pi_flag
//   pi_flag      in   one-cycle byte strobe
//   wr_en        out  one-cycle frame-buffer write strobe
//   wr_addr      out  pixel address (holds between writes)
//   wr_data      out  pixel value (holds between writes)
//   frame_start  out  pulse when the sync header completes
//   frame_done   out  pulse together with the final pixel write
//   busy         out  high while pixels are being loaded
//   err_timeout  out  pulse when a frame is abandoned for an inter-byte gap
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         IMG_W       = 100,
  parameter int         IMG_H       = 100,
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] SYNC0       = SYNC0_DEF,
  parameter logic [7:0] SYNC1       = SYNC1_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        pi_data,
  input  logic              pi_flag,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  frame_state_e      state_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic              gap_run;
  logic              gap_expired;

  assign gap_run = (state_q == ST_SYNC) || (state_q == ST_LOAD);

  byte_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear_i   (pi_flag),
    .run_i     (gap_run),
    .expired_o (gap_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      pix_cnt_q   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Strobes default low; wr_addr/wr_data keep the last written pixel.
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          // DONE is a one-cycle pass-through; a byte arriving there is
          // treated exactly as in IDLE.
          if (pi_flag && (pi_data == SYNC0)) begin
            state_q <= ST_SYNC;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_SYNC: begin
          if (pi_flag) begin
            if (pi_data == SYNC1) begin
              state_q     <= ST_LOAD;
              pix_cnt_q   <= '0;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end else if (pi_data != SYNC0) begin
              // A repeated SYNC0 keeps the header alive.
              state_q <= ST_IDLE;
            end
          end else if (gap_expired) begin
            state_q     <= ST_IDLE;
            err_timeout <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (pi_flag) begin
            // Every byte here is pixel data, including SYNC0/SYNC1 values.
            wr_en   <= 1'b1;
            wr_addr <= pix_cnt_q;
            wr_data <= pi_data;
            if (pix_cnt_q == LAST_PIX) begin
              state_q    <= ST_DONE;
              pix_cnt_q  <= '0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else begin
              pix_cnt_q <= pix_cnt_q + 1'b1;
            end
          end else if (gap_expired) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl
// Directed bench for uart_frame_ctrl with IMG_W=4, IMG_H=2, TIMEOUT_CYC=100.
// A byte-level behavioural model predicts every output each cycle; directed
// sections add literal expectations on the observed write stream.
module tb_uart_frame_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 14;
  localparam int TO_CYC = 100;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b1;
  logic [7:0]        pi_data   = 8'h00;
  logic              pi_flag   = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frame_start;
  logic              frame_done;
  logic              busy;
  logic              err_timeout;

  uart_frame_ctrl #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .ADDR_W      (ADDR_W),
    .SYNC0       (8'h55),
    .SYNC1       (8'hAA),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pi_data     (pi_data),
    .pi_flag     (pi_flag),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model expectations for the outputs after each clock edge.
  logic              e_wr = 1'b0, e_fs = 1'b0, e_fd = 1'b0, e_busy = 1'b0, e_to = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [7:0]        e_data = 8'h00;
  // Model state: 0 hunting for header, 1 first sync seen, 2 taking pixels,
  // 3 frame just finished.
  int     m_mode = 0;
  int     m_idx  = 0;
  longint m_cyc  = 0;
  longint m_last = 0;

  // Observations of the DUT write stream.
  logic [ADDR_W-1:0] wq_a[$];
  logic [7:0]        wq_d[$];
  logic              wq_fd[$];
  int cnt_fs = 0, cnt_fd = 0, cnt_to = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    pi_data = b;
    pi_flag = 1'b1;
    tick(1);
    pi_flag = 1'b0;
    tick(gap);
  endtask

  task automatic send_frame(input logic [7:0] d0);
    send(8'h55, 1);
    send(8'hAA, 1);
    for (int i = 0; i < NPIX; i++) send(8'(d0 + i), 1);
  endtask

  // Eight consecutive writes from queue index base: addr 0..7, data d0+i,
  // frame_done only on the last one.
  task automatic check_frame(input string tag, input int base, input logic [7:0] d0);
    if (wq_a.size() < base + NPIX) begin
      check({tag, "_wrcount"}, 64'(wq_a.size() - base), 64'(NPIX));
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        check({tag, "_addr"}, 64'(wq_a[base+i]), 64'(i));
        check({tag, "_data"}, 64'(wq_d[base+i]), 64'(8'(d0 + i)));
        check({tag, "_fd"},   64'(wq_fd[base+i]), 64'(i == NPIX - 1));
      end
    end
  endtask

  initial begin
    int base, fs0, fd0, to0;
    logic [7:0] pat [8];

    fork
      // Behavioural model: byte-level frame rules, timeout measured as the
      // number of clocks since the last accepted byte.
      forever begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
          m_mode = 0; m_idx = 0;
          e_wr = 0; e_fs = 0; e_fd = 0; e_busy = 0; e_to = 0;
          e_addr = '0; e_data = 8'h00;
        end else begin
          m_cyc++;
          e_wr = 0; e_fs = 0; e_fd = 0; e_to = 0;
          if (pi_flag) begin
            m_last = m_cyc;
            if (m_mode == 0 || m_mode == 3) begin
              m_mode = (pi_data == 8'h55) ? 1 : 0;
            end else if (m_mode == 1) begin
              if (pi_data == 8'hAA) begin
                m_mode = 2; m_idx = 0; e_fs = 1; e_busy = 1;
              end else if (pi_data != 8'h55) begin
                m_mode = 0;
              end
            end else begin
              e_wr = 1; e_addr = ADDR_W'(m_idx); e_data = pi_data;
              if (m_idx == NPIX - 1) begin
                e_fd = 1; m_mode = 3; m_idx = 0; e_busy = 0;
              end else begin
                m_idx++;
              end
            end
          end else if ((m_mode == 1 || m_mode == 2) && (m_cyc - m_last == TO_CYC)) begin
            m_mode = 0; m_idx = 0; e_busy = 0; e_to = 1;
          end else if (m_mode == 3) begin
            m_mode = 0;
          end
        end
      end
      // Per-cycle comparison against the model, plus write-stream capture.
      forever begin
        @(negedge sys_clk);
        check("cycle",
              64'({wr_en, frame_start, frame_done, busy, err_timeout, wr_addr, wr_data}),
              64'({e_wr, e_fs, e_fd, e_busy, e_to, e_addr, e_data}));
        if (wr_en) begin
          wq_a.push_back(wr_addr);
          wq_d.push_back(wr_data);
          wq_fd.push_back(frame_done);
        end
        if (frame_start) cnt_fs++;
        if (frame_done)  cnt_fd++;
        if (err_timeout) cnt_to++;
      end
    join_none

    #3 sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    tick(2);
    check("reset_addr", 64'(wr_addr), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Basic frame 55,AA,01..08.
    base = wq_a.size(); fs0 = cnt_fs; fd0 = cnt_fd;
    send_frame(8'h01);
    tick(3);
    check("f1_fs", 64'(cnt_fs - fs0), 64'd1);
    check("f1_fd", 64'(cnt_fd - fd0), 64'd1);
    check("f1_nwr", 64'(wq_a.size() - base), 64'd8);
    check_frame("f1", base, 8'h01);
    check("f1_busy", 64'(busy), 64'd0);
    check("f1_hold_addr", 64'(wr_addr), 64'd7);

    // Repeated SYNC0 before SYNC1 still opens a frame.
    base = wq_a.size(); fs0 = cnt_fs;
    send(8'h55, 1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 0) send_frame(8'h10);
    end
    tick(3);
    check("f2_fs", 64'(cnt_fs - fs0), 64'd1);
    check_frame("f2", base, 8'h10);

    // Broken header 55,12,AA,... is ignored.
    base = wq_a.size(); fs0 = cnt_fs;
    send(8'h55, 1); send(8'h12, 1); send(8'hAA, 1); send(8'h01, 1); send(8'h02, 1);
    tick(3);
    check("bad_fs", 64'(cnt_fs - fs0), 64'd0);
    check("bad_nwr", 64'(wq_a.size() - base), 64'd0);

    // Gap of 100 idle clocks mid-frame aborts it.
    base = wq_a.size(); to0 = cnt_to; fd0 = cnt_fd;
    send(8'h55, 1); send(8'hAA, 1); send(8'h01, 1); send(8'h02, 1);
    tick(110);
    check("to_pulse", 64'(cnt_to - to0), 64'd1);
    check("to_nwr", 64'(wq_a.size() - base), 64'd2);
    check("to_fd", 64'(cnt_fd - fd0), 64'd0);
    check("to_busy", 64'(busy), 64'd0);
    base = wq_a.size();
    send_frame(8'h21);
    tick(3);
    check_frame("post_to", base, 8'h21);

    // Each byte lands exactly on the limit cycle: no timeout.
    base = wq_a.size(); to0 = cnt_to;
    send(8'h55, 99); send(8'hAA, 99);
    for (int i = 0; i < NPIX; i++) send(8'(8'h30 + i), 99);
    check("edge_to", 64'(cnt_to - to0), 64'd0);
    check_frame("edge", base, 8'h30);

    // Reset after three pixels abandons the frame.
    fd0 = cnt_fd; to0 = cnt_to;
    send(8'h55, 1); send(8'hAA, 1);
    send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
    check("pre_rst_busy", 64'(busy), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_async",
          64'({wr_en, frame_start, frame_done, busy, err_timeout, wr_addr, wr_data}), 64'd0);
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    check("rst_fd", 64'(cnt_fd - fd0), 64'd0);
    check("rst_to", 64'(cnt_to - to0), 64'd0);
    base = wq_a.size();
    send_frame(8'h41);
    tick(3);
    check_frame("post_rst", base, 8'h41);

    // Sync values inside the pixel stream are plain data.
    pat = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
    base = wq_a.size(); fs0 = cnt_fs; fd0 = cnt_fd;
    send(8'h55, 1); send(8'hAA, 1);
    for (int i = 0; i < NPIX; i++) send(pat[i], 1);
    tick(3);
    check("vb_fs", 64'(cnt_fs - fs0), 64'd1);
    check("vb_fd", 64'(cnt_fd - fd0), 64'd1);
    if (wq_d.size() < base + NPIX) begin
      check("vb_nwr", 64'(wq_d.size() - base), 64'(NPIX));
    end else begin
      for (int i = 0; i < NPIX; i++) begin
        check("vb_data", 64'(wq_d[base+i]), 64'(pat[i]));
        check("vb_addr", 64'(wq_a[base+i]), 64'(i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 100, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 100, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 14, write-address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have parameter SYNC0, default 8'h55, first sync byte.
REQ-005 SHALL have parameter SYNC1, default 8'hAA, second sync byte.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 50_000, maximum inter-byte gap in clocks (1 ms at 50 MHz).
REQ-007 SHALL use one clock and an asynchronous, active-low reset: sys_clk  in  1  clock.
REQ-008 sys_rst_n  in  1  asynchronous active-low reset.
REQ-009 pi_data  in  8  received byte, valid when pi_flag=1.
REQ-010 pi_flag  in  1  one-cycle byte-valid strobe from the UART receiver.
REQ-011 wr_en  out  1  one-cycle frame-buffer write strobe.
REQ-012 wr_addr  out  ADDR_W  pixel address, raster order, 0..IMG_W*IMG_H-1.
REQ-013 wr_data  out  8  pixel value.
REQ-014 frame_start  out  1  one-cycle pulse when the sync header completes.
REQ-015 frame_done  out  1  one-cycle pulse when the last pixel is written.
REQ-016 busy  out  1  high while in LOAD.
REQ-017 err_timeout  out  1  one-cycle pulse on an aborted frame.

Function
REQ-018 FSM states: IDLE, SYNC, LOAD, DONE; all outputs registered.
REQ-019 IDLE: pi_flag with pi_data==SYNC0 -> SYNC; any other byte is ignored.
REQ-020 SYNC: pi_flag with SYNC1 -> LOAD and frame_start=1 next cycle; with SYNC0 -> stay in SYNC; with any other byte -> IDLE.
REQ-021 LOAD: each pi_flag -> next cycle wr_en=1, wr_data=pi_data, wr_addr=pix_cnt; pix_cnt then increments.
REQ-022 Latency: pi_flag to wr_en is exactly 1 cycle; no bytes are dropped at a back-to-back pi_flag rate of 1 per 2 cycles or slower.
REQ-023 When pix_cnt==IMG_W*IMG_H-1 and pi_flag=1: go to DONE; frame_done asserts in the same cycle as that final wr_en; pix_cnt resets to 0.
REQ-024 DONE: lasts 1 cycle, then -> IDLE; a pi_flag arriving in DONE is treated as an IDLE byte.
REQ-025 Gap counter: runs in SYNC and LOAD; clears on every pi_flag and on every state entry.
REQ-026 Gap counter reaching TIMEOUT_CYC-1 -> IDLE, pix_cnt=0, err_timeout=1 for 1 cycle, no wr_en.
REQ-027 Simultaneous pi_flag and timeout: pi_flag wins, the byte is processed normally and the counter clears.
REQ-028 wr_addr holds its last value when wr_en=0; wr_data holds likewise.
REQ-029 Sync bytes are never written; pixel bytes equal to SYNC0/SYNC1 in LOAD are written as data.
REQ-030 pix_cnt never exceeds IMG_W*IMG_H-1 (no wrap-around into address 0 mid-frame).

Reset
REQ-031 On sys_rst_n=0: state=IDLE, pix_cnt=0, gap counter=0.
REQ-032 On sys_rst_n=0: wr_en, frame_start, frame_done, busy, err_timeout = 0; wr_addr = 0; wr_data = 8'h00.
REQ-033 Reset mid-LOAD abandons the frame with no frame_done or err_timeout pulse; the next frame requires a new sync header.

Structure
REQ-034 State encodings, SYNC0/SYNC1 defaults and the TIMEOUT_CYC default SHALL live in a shared include, uart_frame_pkg.
REQ-035 The gap counter SHALL be a sub-module, byte_gap_timer (inputs: clear, run; output: expired pulse).
REQ-036 uart_frame_ctrl SHALL connect directly to the UART receiver's po_data/po_flag outputs.

Verification (IMG_W=4, IMG_H=2, TIMEOUT_CYC=100)
REQ-037 Bytes 55,AA,01..08 -> frame_start once; 8 wr_en at addrs 0..7 with data 01..08; frame_done coincident with addr 7; busy low afterward.
REQ-038 Bytes 55,55,AA,10..17 -> frame accepted; bytes 55,12,AA,... -> no frame_start, no wr_en.
REQ-039 55,AA,01,02, then a 100-cycle gap -> err_timeout pulse, state IDLE; a following full frame writes starting at addr 0.
REQ-040 pi_flag on the cycle the gap counter reaches 99 -> byte written, no err_timeout.
REQ-041 Reset asserted after 3 pixels -> all outputs 0 immediately; no frame_done; the next frame starts at addr 0.
REQ-042 Pixel data containing 55/AA inside LOAD -> written verbatim, with no resync.
